// File: rtl/scpu_pkg.sv
// Shared instruction-format definitions for the simple_cpu control path and its sequencer.
package scpu_pkg;

  localparam int unsigned CNT_W = 8;

  localparam int OP_MSB  = 19;
  localparam int OP_LSB  = 18;
  localparam int X1_MSB  = 17;
  localparam int X1_LSB  = 16;
  localparam int X2_MSB  = 15;
  localparam int X2_LSB  = 14;
  localparam int X3_MSB  = 13;
  localparam int X3_LSB  = 12;
  localparam int IMM_MSB = 11;
  localparam int IMM_LSB = 4;
  localparam int FN_MSB  = 3;
  localparam int FN_LSB  = 0;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_ALU    = 2'b01,
    OP_LOADR  = 2'b10,
    OP_STORER = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DONE
  } state_e;

  // Number of consecutive cycles an instruction must stay on the CPU input.
  function automatic int unsigned hold_cycles(input opcode_e     op,
                                              input int unsigned alu_cycles,
                                              input int unsigned load_cycles,
                                              input int unsigned store_cycles);
    int unsigned n;
    case (op)
      OP_NOP:    n = 1;
      OP_ALU:    n = alu_cycles;
      OP_LOADR:  n = load_cycles;
      OP_STORER: n = store_cycles;
      default:   n = 1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Single-write-port program store with asynchronous read and write-first forwarding.
module prog_ram #(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata = r_mem[i_raddr];
    if (i_we && (i_waddr == i_raddr)) begin
      o_rdata = i_wdata;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Issues a stored program to the simple_cpu, holding each word for its opcode's cycle count.
module instr_sequencer
  import scpu_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH    = 20,
  parameter int unsigned PROG_ADDR_BITS = 4,
  parameter int unsigned ALU_CYCLES     = 3,
  parameter int unsigned STORE_CYCLES   = 3,
  parameter int unsigned LOAD_CYCLES    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      prog_we,
  input  logic [PROG_ADDR_BITS-1:0] prog_addr,
  input  logic [INSTR_WIDTH-1:0]    prog_wdata,
  input  logic [PROG_ADDR_BITS:0]   prog_len,
  input  logic                      start,
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic [PROG_ADDR_BITS-1:0] pc,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned LEN_W = PROG_ADDR_BITS + 1;
  localparam int unsigned DEPTH = 1 << PROG_ADDR_BITS;

  state_e                    r_state;
  logic [INSTR_WIDTH-1:0]    r_instr;
  logic [PROG_ADDR_BITS-1:0] r_pc;
  logic                      r_busy;
  logic                      r_done;
  logic [CNT_W-1:0]          r_cnt;
  logic [LEN_W-1:0]          r_len;

  logic                      w_we;
  logic [PROG_ADDR_BITS-1:0] w_raddr;
  logic [INSTR_WIDTH-1:0]    w_rdata;
  logic [CNT_W-1:0]          w_hold_m1;
  logic [LEN_W-1:0]          w_len_clamp;
  logic                      w_last;

  assign w_we        = prog_we && (r_state != ST_ISSUE);
  // Idle always looks at word 0 so a same-cycle write to it is forwarded into the first issue.
  assign w_raddr     = (r_state == ST_ISSUE) ? r_pc + PROG_ADDR_BITS'(1) : '0;
  assign w_hold_m1   = CNT_W'(hold_cycles(opcode_e'(w_rdata[OP_MSB:OP_LSB]), ALU_CYCLES,
                                          LOAD_CYCLES, STORE_CYCLES) - 1);
  assign w_len_clamp = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
  assign w_last      = ({1'b0, r_pc} == (r_len - LEN_W'(1)));

  prog_ram #(
    .DATA_W(INSTR_WIDTH),
    .ADDR_W(PROG_ADDR_BITS)
  ) u_prog_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_instr <= '0;
      r_pc    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len <= w_len_clamp;
            if (w_len_clamp != '0) begin
              r_state <= ST_ISSUE;
              r_pc    <= '0;
              r_instr <= w_rdata;
              r_cnt   <= w_hold_m1;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (!w_last) begin
            r_pc    <= r_pc + PROG_ADDR_BITS'(1);
            r_instr <= w_rdata;
            r_cnt   <= w_hold_m1;
          end else begin
            r_state <= ST_DONE;
            r_instr <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign instruction = r_instr;
  assign pc          = r_pc;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
